// File: rtl/tlb_test_port.sv
// -----------------------------------------------------------------------------
// tlb_test_port
//   Consumer side of the TR6/TR7 test registers. It watches the test-register
//   write bus; a write to TR6 launches one command against the 4-way TLB array.
//   C=0 writes an entry built from TR6/TR7. C=1 looks up the addressed set and
//   returns the result as a one-cycle load into TR7. While a command is in
//   flight, busy is raised so the core holds off further MOV TRn.
//
// Ports
//   clock, reset          clock and asynchronous active-high reset
//   tr_write_enable/index/data   snooped test-register write bus
//   tr7_value             current TR7 contents (captured at trigger)
//   tlb_repl_way          replacement way for the addressed set (captured at trigger)
//   tlb_req/we/set/way/wdata     TLB access request, held until tlb_ack
//   tlb_ack               request accepted; tlb_rdata valid in that cycle on reads
//   tlb_rdata             four entries of the set, way0 in the LSBs
//   tr7_load_enable/data  one-cycle TR7 load with the lookup result
//   busy                  command in flight
//   op_done               one-cycle pulse at command completion
//
// Entry layout (44-SET_BITS bits): {tag, V, D, U, W, phys[31:12]}
// -----------------------------------------------------------------------------
module tlb_test_port #(
    parameter int         SET_BITS  = 3,
    parameter logic [2:0] TR6_INDEX = 3'd6,
    parameter logic [2:0] TR7_INDEX = 3'd7
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        tr_write_enable,
    input  logic [2:0]                  tr_write_index,
    input  logic [31:0]                 tr_write_data,
    input  logic [31:0]                 tr7_value,
    input  logic [1:0]                  tlb_repl_way,
    output logic                        tlb_req,
    output logic                        tlb_we,
    output logic [SET_BITS-1:0]         tlb_set,
    output logic [1:0]                  tlb_way,
    output logic [43-SET_BITS:0]        tlb_wdata,
    input  logic                        tlb_ack,
    input  logic [4*(44-SET_BITS)-1:0]  tlb_rdata,
    output logic                        tr7_load_enable,
    output logic [31:0]                 tr7_load_data,
    output logic                        busy,
    output logic                        op_done
);

    localparam int EW = 44 - SET_BITS;   // entry width

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [19:0] lin_q,    lin_d;      // linear[31:12] from TR6
    logic [6:0]  attr_q,   attr_d;     // {V, D, D#, U, U#, W, W#}
    logic        lookup_q, lookup_d;   // C bit
    logic [19:0] phys_q,   phys_d;     // TR7 phys[31:12]
    logic [1:0]  way_q,    way_d;
    logic [31:0] result_q, result_d;

    logic        trigger;
    logic [3:0]  hit;
    logic [19:0] way_phys [4];
    logic [31:0] lookup_result;

    // A misconfigured parameter set with both indices equal never triggers.
    assign trigger = tr_write_enable && (tr_write_index == TR6_INDEX) &&
                     (TR6_INDEX != TR7_INDEX) && (state_q == ST_IDLE);

    // Attribute pair (X, X#): 10 needs bit=1, 01 needs bit=0, 11 ignores it,
    // 00 can never match.
    function automatic logic pair_ok(input logic x, input logic xn, input logic b);
        return (x | xn) & (x | ~b) & (xn | b);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_way
            logic [EW-1:0] ent;
            assign ent          = tlb_rdata[gi*EW +: EW];
            assign way_phys[gi] = ent[19:0];
            assign hit[gi]      = ent[23] & attr_q[6] &
                                  (ent[EW-1:24] == lin_q[19:SET_BITS]) &
                                  pair_ok(attr_q[5], attr_q[4], ent[22]) &
                                  pair_ok(attr_q[3], attr_q[2], ent[21]) &
                                  pair_ok(attr_q[1], attr_q[0], ent[20]);
        end
    endgenerate

    // Scan from way 3 down so the lowest hitting way is the one reported.
    always_comb begin
        lookup_result = 32'h0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                lookup_result = {way_phys[i], 7'b0, 1'b1, 2'(i), 2'b0};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        lin_d    = lin_q;
        attr_d   = attr_q;
        lookup_d = lookup_q;
        phys_d   = phys_q;
        way_d    = way_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d  = ST_REQ;
                    lin_d    = tr_write_data[31:12];
                    attr_d   = tr_write_data[11:5];
                    lookup_d = tr_write_data[0];
                    phys_d   = tr7_value[31:12];
                    way_d    = tr7_value[4] ? tr7_value[3:2] : tlb_repl_way;
                    result_d = 32'h0;
                end
            end
            ST_REQ: begin
                if (tlb_ack) begin
                    state_d = ST_FINISH;
                    if (lookup_q) begin
                        result_d = lookup_result;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lin_q    <= '0;
            attr_q   <= '0;
            lookup_q <= 1'b0;
            phys_q   <= '0;
            way_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lin_q    <= lin_d;
            attr_q   <= attr_d;
            lookup_q <= lookup_d;
            phys_q   <= phys_d;
            way_q    <= way_d;
            result_q <= result_d;
        end
    end

    // All outputs derive from reset registers, so reset clears them at once.
    assign tlb_req         = (state_q == ST_REQ);
    assign tlb_we          = tlb_req & ~lookup_q;
    assign tlb_set         = lin_q[SET_BITS-1:0];
    assign tlb_way         = way_q;
    assign tlb_wdata       = {lin_q[19:SET_BITS], attr_q[6], attr_q[5], attr_q[3],
                              attr_q[1], phys_q};
    assign tr7_load_enable = (state_q == ST_FINISH) & lookup_q;
    assign tr7_load_data   = result_q;
    assign busy            = (state_q != ST_IDLE);
    assign op_done         = (state_q == ST_FINISH);

    // TR6 bits 4:1 and TR7 bits 11:5, 1:0 carry nothing this block needs.
    logic unused_bits;
    assign unused_bits = ^{tr_write_data[4:1], tr7_value[11:5], tr7_value[1:0]};

endmodule
